alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It adds the following:
- a configurable operand width;
- a 3-bit opcode space that includes shifts, compare and a multi-cycle shift-add multiply;
- a persistent carry flag for multi-word add, subtract and rotate chains;
- valid/ready handshakes on both input and output.

It sits between the datapath's operand registers and its writeback stage.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready on the issue side
// and on the writeback side.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             use_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;

  modport master (
    output in_valid, a, b, op, use_carry, out_ready,
    input  in_ready, out_valid, out, zero, carry
  );

  modport slave (
    input  in_valid, a, b, op, use_carry, out_ready,
    output in_ready, out_valid, out, zero, carry
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with a persistent carry flag and a WIDTH-step shift-add multiply.
// Single-cycle ops complete on the accepting edge; MUL runs WIDTH steps plus one finalize cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nx;
  logic                 accept, is_mul, mul_last;
  logic                 cflag, cin;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_upd;
  logic [WIDTH-1:0]     out_q;
  logic                 zero_q, carry_q;

  // In DONE the consumer's ready passes straight through so retire and issue share an edge.
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign is_mul   = (bus.op == 3'd6);
  assign mul_last = (state == MUL) && (cnt == CW'(WIDTH));
  assign cin      = bus.use_carry & cflag;

  always_comb begin
    sum     = '0;
    res     = '0;
    res_c   = 1'b0;
    res_upd = 1'b1;
    case (bus.op)
      3'd0: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      3'd1: begin
        sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, (bus.use_carry ? cflag : 1'b1)};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      3'd2: begin
        res     = ~(bus.a & bus.b);
        res_upd = 1'b0;
      end
      3'd3: begin
        res     = bus.a ^ bus.b;
        res_upd = 1'b0;
      end
      3'd4: begin
        res   = {bus.a[WIDTH-2:0], cin};
        res_c = bus.a[WIDTH-1];
      end
      3'd5: begin
        res   = {cin, bus.a[WIDTH-1:1]};
        res_c = bus.a[0];
      end
      3'd7: begin
        sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        res   = bus.a;
        res_c = sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                            state_nx = is_mul ? MUL : DONE;
        else if (state == DONE && bus.out_ready) state_nx = IDLE;
      end
      MUL:     if (mul_last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cflag   <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, bus.a};
        mplier <= bus.b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        out_q   <= res;
        zero_q  <= (res == '0);
        carry_q <= res_c;
        if (res_upd) cflag <= res_c;
      end
    end else if (state == MUL) begin
      if (mul_last) begin
        out_q   <= acc[WIDTH-1:0];
        zero_q  <= (acc[WIDTH-1:0] == '0);
        carry_q <= |acc[2*WIDTH-1:WIDTH];
        cflag   <= |acc[2*WIDTH-1:WIDTH];
      end else begin
        // Full-length iteration regardless of operand values keeps MUL latency fixed.
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: back-to-back single-cycle ops, carry chains,
// MUL latency, output backpressure and reset during a multiply.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic uc);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.use_carry = uc;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] o, input logic z, input logic c);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_out"},   {24'd0, bus.out}, {24'd0, o});
    chk({tag, "_zero"},  {31'd0, bus.zero}, {31'd0, z});
    chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, c});
  endtask

  // Counts cycles after an accepting edge until out_valid appears (0 if it never does).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (bus.out_valid) lat = i;
    end
  endtask

  initial begin
    int lat;
    int bad;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = 3'd0; bus.a = 8'd0; bus.b = 8'd0; bus.use_carry = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out",       {24'd0, bus.out}, 32'd0);
    chk("rst_zero",      {31'd0, bus.zero}, 32'd0);
    chk("rst_carry",     {31'd0, bus.carry}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back single-cycle ops, each result one cycle after acceptance.
    drive(3'd1, 8'd3, 8'd5, 1'b0); tick(); chk_res("sub35", 8'hFE, 1'b0, 1'b0);
    drive(3'd0, 8'd3, 8'd5, 1'b0); tick(); chk_res("add35", 8'h08, 1'b0, 1'b0);
    drive(3'd2, 8'd3, 8'd5, 1'b0); tick(); chk_res("nand35", 8'hFE, 1'b0, 1'b0);
    drive(3'd1, 8'd3, 8'd3, 1'b0); tick(); chk_res("sub33", 8'h00, 1'b1, 1'b1);
    drive(3'd1, 8'd3, 8'd2, 1'b0); tick(); chk_res("sub32", 8'h01, 1'b0, 1'b1);

    // Two-word add 0x01FF + 0x0001.
    drive(3'd0, 8'hFF, 8'h01, 1'b0); tick(); chk_res("add_lo", 8'h00, 1'b1, 1'b1);
    drive(3'd0, 8'h01, 8'h00, 1'b1); tick(); chk_res("add_hi", 8'h02, 1'b0, 1'b0);

    // All-ones + 1 + carry-in.
    drive(3'd1, 8'd3, 8'd3, 1'b0); tick();
    drive(3'd0, 8'hFF, 8'h01, 1'b1); tick(); chk_res("add_chain", 8'h01, 1'b0, 1'b1);
    drive(3'd5, 8'h02, 8'h00, 1'b1); tick(); chk_res("shr_uc", 8'h81, 1'b0, 1'b0);
    drive(3'd7, 8'd5, 8'd3, 1'b0);   tick(); chk_res("cmp53", 8'h05, 1'b0, 1'b1);
    drive(3'd3, 8'h0F, 8'hFF, 1'b0); tick(); chk_res("xor", 8'hF0, 1'b0, 1'b0);
    drive(3'd0, 8'h00, 8'h00, 1'b1); tick(); chk_res("add_keep_cf", 8'h01, 1'b0, 1'b0);
    bus.in_valid = 1'b0; tick();
    chk("drain_idle", {31'd0, bus.out_valid}, 32'd0);

    // MUL latency and flags.
    drive(3'd6, 8'h10, 8'h10, 1'b0); tick();
    bus.in_valid = 1'b0;
    chk("mul_busy", {31'd0, bus.in_ready}, 32'd0);
    wait_valid(lat);
    chk("mul1_lat", lat, 32'd9);
    chk_res("mul1", 8'h00, 1'b1, 1'b1);
    drive(3'd6, 8'd7, 8'd9, 1'b1); tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("mul2_lat", lat, 32'd9);
    chk_res("mul2", 8'd63, 1'b0, 1'b0);
    tick();

    // Output backpressure.
    bus.out_ready = 1'b0;
    drive(3'd0, 8'h20, 8'h22, 1'b0); tick();
    drive(3'd3, 8'hAA, 8'h55, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out !== 8'h42 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    chk("stall_hold", bad, 32'd0);
    chk_res("stall_res", 8'h42, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk_res("retire_accept", 8'hFF, 1'b0, 1'b0);
    bus.in_valid = 1'b0; tick();

    // Reset on the 4th MUL cycle after loading cflag = 1.
    drive(3'd1, 8'd3, 8'd3, 1'b0); tick();
    drive(3'd6, 8'hFF, 8'hFF, 1'b0); tick();
    bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      tick();
    end
    chk("rst_mul_no_valid", bad, 32'd0);
    chk("rst_mul_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(3'd4, 8'h80, 8'h00, 1'b1); tick();
    chk_res("shl_after_rst", 8'h00, 1'b1, 1'b1);
    bus.in_valid = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
